// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: opcodes, FSM states
// and the iteration counter width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Counter has one spare bit so it can hold WIDTH itself without wrapping.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MDU_CNT_W = cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, shift in the quotient bit.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // quo_i carries the not-yet-consumed dividend bits in its upper part.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (shifted >= {1'b0, dvs_i}) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV unit with HI/LO registers; one bit per cycle, WIDTH RUN
// cycles per op, start/busy handshake and a one-cycle done pulse.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dvz_q, dvz_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_shr, div_rem, div_quo;
  logic [WIDTH-1:0] step_acc, step_shr, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q),
    .quo_i (shr_q),
    .dvs_i (mcand_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Signed ops iterate on magnitudes; signs are reapplied on the last edge.
  always_comb begin
    a_neg = op[0] & A[WIDTH-1];
    b_neg = op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  // Multiply: {acc, shr} holds partial product over the remaining multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (shr_q[0] ? mcand_q : '0)};
    mul_acc  = mul_sum[WIDTH:1];
    mul_shr  = {mul_sum[0], shr_q[WIDTH-1:1]};
    step_acc = is_div_q ? div_rem : mul_acc;
    step_shr = is_div_q ? div_quo : mul_shr;
    prod     = {step_acc, step_shr};
    if (is_div_q) begin
      res_lo = dvz_q ? '1 : (neg_res_q ? -step_shr : step_shr);
      res_hi = neg_rem_q ? -step_acc : step_acc;
    end else begin
      {res_hi, res_lo} = neg_res_q ? -prod : prod;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    shr_d     = shr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      RUN: begin
        acc_d = step_acc;
        shr_d = step_shr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIN;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: begin
        // IDLE and FIN both accept; reserved opcodes simply land in IDLE.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          case (op)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              state_d   = RUN;
              busy_d    = 1'b1;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dvz_d     = (B == '0);
              acc_d     = '0;
              mcand_d   = op[1] ? b_mag : a_mag;
              shr_d     = op[1] ? a_mag : b_mag;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      shr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dvz_q     <= dvz_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      shr_q     <= shr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit that sits beside the single-cycle ALU in the datapath. It takes the same A/B operands and a 3-bit opcode, and runs multi-cycle MULT/DIV operations into dedicated HI/LO registers. The pipeline issues a request with a start/busy handshake, stalls while busy is high, and reads HI/LO after the done pulse.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits and each iterative op takes WIDTH RUN cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only when busy=0
op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved
A  input  WIDTH  operand A / dividend / MTHI-MTLO source
B  input  WIDTH  operand B / divisor
busy  output  1  high while a MULT/DIV iterates
done  output  1  one-cycle pulse when HI/LO take a MULT/DIV result
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): the FSM goes to IDLE, the counter goes to 0, and busy=0, done=0, HI=0, LO=0. Reset mid-operation aborts the op and discards the result.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1; the counter runs 0..WIDTH-1.
  - FIN: busy=0, done=1 for exactly one cycle.
- Acceptance: a request is accepted at an edge where start=1 and the FSM is in IDLE or FIN. A start while in RUN is ignored: no latch, no state change.
- MULT/DIV accept: latch op and A, B (as magnitudes for the signed ops, plus sign flags) and go to RUN. A/B may change afterwards with no effect.
- MTHI/MTLO accept: HI<=A (MTHI) or LO<=A (MTLO) at the accepting edge. The FSM goes to IDLE; busy and done stay 0.
- Reserved opcodes: ignored entirely; the FSM goes to IDLE.
- Latency: with a start edge at t0, busy is high in cycles t0+1 .. t0+WIDTH. At the last RUN edge HI/LO are written, the FSM enters FIN, and done=1 in cycle t0+WIDTH+1. The result is visible in that same cycle.
- Back-to-back: a start during FIN is accepted, so the next op begins with no idle bubble.
- HI/LO hold their previous values throughout RUN.
- Multiply: shift-add, one bit per cycle. Result {HI,LO} = full 2*WIDTH product. MULT is signed (two's complement); MULTU is unsigned.
- Divide: restoring, one quotient bit per cycle. LO = quotient, HI = remainder. DIV truncates toward zero and the remainder takes the sign of the dividend. DIVU is unsigned.
- Divide by zero (still takes the full WIDTH cycles):
  - DIVU: LO = all ones, HI = A.
  - DIV: LO = all ones (-1), HI = A.
- Overflow: DIV of most-negative / -1 gives LO = most-negative, HI = 0.
- The FIN to IDLE transition happens when start=0.

Decomposition:
- Package mdu_pkg: opcode localparams (MULTU..MTLO), FSM state enum {IDLE, RUN, FIN}, and a counter width constant of $clog2(WIDTH)+1.
- One natural sub-module: mdu_div_step. It is combinational and performs one restoring-division iteration: {rem, quo} in, {rem, quo} out. It is instantiated once in mdu_iter.
- The multiply step is kept inline in mdu_iter.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at t0 -> busy high t0+1..t0+32, done at t0+33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); then DIVU A=7 B=2 started in the FIN cycle -> accepted, LO=3, HI=1 after 33 cycles.
- DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x00001234 B=0 -> LO=0xFFFFFFFF, HI=0x00001234; DIV A=0xFFFFFF00 B=0 -> LO=0xFFFFFFFF, HI=0xFFFFFF00.
- MTHI A=0xDEADBEEF when idle -> HI=0xDEADBEEF the next cycle, busy/done stay 0. Then MTLO issued during a running MULT -> ignored, and LO gets the MULT result.
- rst_n driven low at t0+10 of a DIV -> busy=0, done=0, HI=LO=0 immediately (asynchronous, before the next edge); no done pulse follows after reset is released.
